sdram_multiport_arbiter: RTL and testbench
==========================================

Name: sdram_multiport_arbiter

Overview:
- Single-clock-domain arbiter between N SDRAM-side port requesters (wb_port internal interfaces) and the SDRAM controller core.
- Parametrised successor to the fixed 3-port round-robin arbiter. Adds data/address width generics, selectable round-robin or fixed-priority policy, per-grant burst quota, explicit grant/drain state machine, and grant status outputs.
- Sits between the per-port CDC buffers and the controller's adr/dat/acc/ack interface.

Parameters:
- PORTS, 3, number of requesting ports (>=2)
- AW, 32, address width
- DW, 16, data width (multiple of 8)
- ARB_MODE, 0, 0 = round-robin starting after last grant; 1 = fixed priority, lowest index wins
- QUOTA, 8, max acks per grant while another port waits; 0 = unlimited
- AGE_LIMIT, 64, cycles a port may wait before promotion (SDRAM_ARB_AGING_EN only)

Ports:
- sdram_clk  in  1  clock
- sdram_rst  in  1  asynchronous reset, active-high
- p_acc_i  in  PORTS  per-port access request
- p_adr_i  in  PORTS*AW  per-port address, port i at [i*AW +: AW]
- p_dat_i  in  PORTS*DW  per-port write data
- p_sel_i  in  PORTS*DW/8  per-port byte selects
- p_we_i  in  PORTS  per-port write enable
- p_ack_o  out  PORTS  per-port ack
- p_dat_o  out  DW  read data broadcast to all ports (= dat_i)
- sdram_idle_i  in  1  controller idle, no transfer in flight
- acc_o  out  1  access request to controller
- adr_o  out  AW  muxed address
- dat_o  out  DW  muxed write data
- sel_o  out  DW/8  muxed selects
- we_o  out  1  muxed write enable
- ack_i  in  1  controller ack
- dat_i  in  DW  controller read data
- grant_o  out  PORTS  one-hot current grant
- grant_enc_o  out  clog2(PORTS)  encoded grant

Behaviour:
- Reset (async, any cycle, including mid-burst):
  - state IDLE, grant_o = 1 (port 0), grant_enc_o = 0, quota counter = 0, acc_o = 0, p_ack_o = 0.
  - adr_o/dat_o/sel_o/we_o follow port 0 inputs.
- Muxes:
  - adr_o/dat_o/sel_o/we_o always select the granted port combinationally.
  - p_ack_o[g] = ack_i in BUSY and DRAIN; all other bits 0; all bits 0 in IDLE.
- State IDLE:
  - acc_o = 0.
  - If |p_acc_i and sdram_idle_i: register new grant, go BUSY. acc_o rises the next cycle, so request-to-acc_o latency is 1 cycle minimum.
  - Round-robin mode: search from (last grant + 1) mod PORTS. A sole requester equal to the last grant is re-granted.
- State BUSY:
  - acc_o = p_acc_i[g].
  - Counter increments on ack_i; counter width clog2(QUOTA+1).
  - p_acc_i[g] falls → DRAIN.
  - ack_i when counter == QUOTA-1 (QUOTA != 0) and any other p_acc_i set → acc_o forced 0 from next cycle, go DRAIN.
  - Same quota hit with no other requester → counter clears, stay BUSY.
- State DRAIN:
  - acc_o = 0; late ack_i is still routed to g.
  - On sdram_idle_i: go IDLE, counter clears.
  - Grant never changes outside the IDLE→BUSY transition.
- Simultaneous events:
  - Quota hit and p_acc_i[g] falling in the same cycle → DRAIN (single transition).
  - sdram_idle_i high in DRAIN with pending requests → IDLE for 1 cycle, then BUSY. Switch gap is 2 cycles minimum.
- Fixed-priority mode: quota still applies, so a lower port is served once the higher port hits QUOTA while the lower port is waiting.

Optional Feature:
- Macro: SDRAM_ARB_AGING_EN.
- When defined:
  - Per-port wait counters (clog2(AGE_LIMIT+1) bits) increment each cycle the port requests and is not granted/BUSY, and clear on grant.
  - In IDLE, any port whose counter reached AGE_LIMIT wins over the policy choice; among several aged ports, the lowest index wins.
  - Counters saturate and reset to 0.
- When undefined: no counters, pure ARB_MODE policy, identical cycle behaviour otherwise.

Test Plan:
- Reset mid-BUSY (port 1 granted, 3 acks done) → acc_o = 0 and grant_o = 3'b001 immediately; counter 0 after release.
- RR mode, ports 0,1,2 requesting continuously, QUOTA=4, sdram_idle_i pulses 1 cycle after each acc_o fall → grant sequence 1,2,0,1, each with exactly 4 p_ack_o pulses.
- Single requester port 2, QUOTA=4, 10 acks → stays BUSY throughout, 10 p_ack_o[2] pulses, no DRAIN.
- ARB_MODE=1, ports 0 and 2 requesting, QUOTA=2 → port 0 gets 2 acks, then port 2 gets 2, then port 0; p_ack_o[1] never asserts.
- Late ack_i in DRAIN after p_acc_i[g] falls → routed to p_ack_o[g] only; grant holds until sdram_idle_i = 1.
- SDRAM_ARB_AGING_EN, ARB_MODE=1, AGE_LIMIT=16, QUOTA=0, port 0 continuous, port 2 waiting → port 2 granted at first IDLE after 16 wait cycles.

Source files
------------

// File: rtl/sdram_multiport_arbiter_if.sv
// Bus bundle between the per-port CDC buffers, the arbiter and the SDRAM
// controller core.
// master: arbiter side (drives acc_o/adr_o/dat_o/sel_o/we_o, p_ack_o, p_dat_o)
// slave : environment side (port requests, controller ack/data/idle)
interface sdram_multiport_arbiter_if #(
    parameter int PORTS = 3,
    parameter int AW    = 32,
    parameter int DW    = 16
);
    // port side
    logic [PORTS-1:0]        p_acc_i;
    logic [PORTS*AW-1:0]     p_adr_i;
    logic [PORTS*DW-1:0]     p_dat_i;
    logic [PORTS*DW/8-1:0]   p_sel_i;
    logic [PORTS-1:0]        p_we_i;
    logic [PORTS-1:0]        p_ack_o;
    logic [DW-1:0]           p_dat_o;
    // controller side
    logic                    sdram_idle_i;
    logic                    acc_o;
    logic [AW-1:0]           adr_o;
    logic [DW-1:0]           dat_o;
    logic [DW/8-1:0]         sel_o;
    logic                    we_o;
    logic                    ack_i;
    logic [DW-1:0]           dat_i;

    modport master (
        input  p_acc_i, p_adr_i, p_dat_i, p_sel_i, p_we_i,
        input  sdram_idle_i, ack_i, dat_i,
        output p_ack_o, p_dat_o,
        output acc_o, adr_o, dat_o, sel_o, we_o
    );

    modport slave (
        output p_acc_i, p_adr_i, p_dat_i, p_sel_i, p_we_i,
        output sdram_idle_i, ack_i, dat_i,
        input  p_ack_o, p_dat_o,
        input  acc_o, adr_o, dat_o, sel_o, we_o
    );
endinterface

// File: rtl/sdram_multiport_arbiter.sv
// N-port arbiter in front of the SDRAM controller core: round-robin or
// fixed-priority grant, per-grant ack quota, IDLE/BUSY/DRAIN grant FSM.
// Ports: sdram_clk, sdram_rst (async, active-high), bus (master modport of
// sdram_multiport_arbiter_if), grant_o (one-hot), grant_enc_o (encoded).
// Optional: define SDRAM_ARB_AGING_EN for per-port wait-age promotion.
module sdram_multiport_arbiter #(
    parameter int PORTS     = 3,
    parameter int AW        = 32,
    parameter int DW        = 16,
    parameter int ARB_MODE  = 0,
    parameter int QUOTA     = 8,
    parameter int AGE_LIMIT = 64
) (
    input  logic                       sdram_clk,
    input  logic                       sdram_rst,
    sdram_multiport_arbiter_if.master  bus,
    output logic [PORTS-1:0]           grant_o,
    output logic [$clog2(PORTS)-1:0]   grant_enc_o
);
    localparam int GW = $clog2(PORTS);
    localparam int SW = DW / 8;
    localparam int CW = (QUOTA > 0) ? $clog2(QUOTA + 1) : 1;

    if (PORTS < 2 || (DW % 8) != 0 || AGE_LIMIT < 1) begin : g_cfg_err
        $error("sdram_multiport_arbiter: bad parameters");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            qexp;
    logic [PORTS-1:0] others;
    logic [PORTS-1:0] req;
    logic [PORTS-1:0] aged;
    logic [GW-1:0]   pick_enc;
    logic            quota_hit;
    logic            start;
    logic            found;
    int              idx;

    // muxes and ack routing
    assign bus.adr_o   = bus.p_adr_i[grant_enc_o*AW +: AW];
    assign bus.dat_o   = bus.p_dat_i[grant_enc_o*DW +: DW];
    assign bus.sel_o   = bus.p_sel_i[grant_enc_o*SW +: SW];
    assign bus.we_o    = |(bus.p_we_i & grant_o);
    assign bus.acc_o   = (state == BUSY) && |(bus.p_acc_i & grant_o);
    assign bus.p_ack_o = (state != IDLE && bus.ack_i) ? grant_o : '0;
    assign bus.p_dat_o = bus.dat_i;

    assign others    = bus.p_acc_i & ~grant_o;
    assign quota_hit = (QUOTA != 0) && bus.ack_i &&
                       (cnt == CW'(QUOTA - 1));
    assign start     = |bus.p_acc_i && bus.sdram_idle_i;

    // A port whose grant ended on quota sits out the next arbitration
    // when anyone else wants the bus; this is what lets fixed priority
    // ever serve a lower port.
    always_comb begin
        req = bus.p_acc_i;
        if (qexp && |others)
            req = others;
    end

    always_comb begin
        pick_enc = grant_enc_o;
        found    = 1'b0;
        idx      = 0;
        if (|(aged & bus.p_acc_i)) begin
            for (int i = 0; i < PORTS; i++) begin
                if (!found && aged[i] && bus.p_acc_i[i]) begin
                    pick_enc = i[GW-1:0];
                    found    = 1'b1;
                end
            end
        end else if (ARB_MODE == 1) begin
            for (int i = 0; i < PORTS; i++) begin
                if (!found && req[i]) begin
                    pick_enc = i[GW-1:0];
                    found    = 1'b1;
                end
            end
        end else begin
            // search starts one past the last grant, wraps onto it
            for (int i = 1; i <= PORTS; i++) begin
                idx = (int'(grant_enc_o) + i) % PORTS;
                if (!found && req[idx]) begin
                    pick_enc = idx[GW-1:0];
                    found    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            state       <= IDLE;
            grant_o     <= PORTS'(1);
            grant_enc_o <= '0;
            cnt         <= '0;
            qexp        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        grant_o     <= PORTS'(1) << pick_enc;
                        grant_enc_o <= pick_enc;
                        cnt         <= '0;
                        qexp        <= 1'b0;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.ack_i)
                        cnt <= cnt + 1'b1;
                    if (quota_hit && |others) begin
                        qexp  <= 1'b1;
                        state <= DRAIN;
                    end else begin
                        if (quota_hit)
                            cnt <= '0;
                        if (!(|(bus.p_acc_i & grant_o)))
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.sdram_idle_i) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SDRAM_ARB_AGING_EN
    localparam int AGW = $clog2(AGE_LIMIT + 1);

    logic [AGW-1:0] age [PORTS];

    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            for (int i = 0; i < PORTS; i++)
                age[i] <= '0;
        end else begin
            for (int i = 0; i < PORTS; i++) begin
                if ((state == IDLE && start && pick_enc == i[GW-1:0]) ||
                    (state != IDLE && grant_o[i]))
                    age[i] <= '0;
                else if (bus.p_acc_i[i] && age[i] != AGW'(AGE_LIMIT))
                    age[i] <= age[i] + 1'b1;
            end
        end
    end

    always_comb begin
        aged = '0;
        for (int i = 0; i < PORTS; i++)
            aged[i] = (age[i] == AGW'(AGE_LIMIT));
    end
`else
    assign aged = '0;
`endif

endmodule

// File: tb/tb_sdram_multiport_arbiter.sv
// Directed bench: round-robin/quota instance and fixed-priority instance
// of sdram_multiport_arbiter, driven by hand-written vectors.
module tb_sdram_multiport_arbiter;

    logic sdram_clk = 1'b0;
    logic sdram_rst = 1'b1;

    always #5 sdram_clk = ~sdram_clk;

    sdram_multiport_arbiter_if #(.PORTS(3), .AW(32), .DW(16)) ifa ();
    sdram_multiport_arbiter_if #(.PORTS(3), .AW(32), .DW(16)) ifb ();

    logic [2:0] ga, gb;
    logic [1:0] gea, geb;

    sdram_multiport_arbiter #(
        .PORTS(3), .AW(32), .DW(16),
        .ARB_MODE(0), .QUOTA(4), .AGE_LIMIT(64)
    ) dut_rr (
        .sdram_clk   (sdram_clk),
        .sdram_rst   (sdram_rst),
        .bus         (ifa),
        .grant_o     (ga),
        .grant_enc_o (gea)
    );

    sdram_multiport_arbiter #(
        .PORTS(3), .AW(32), .DW(16),
        .ARB_MODE(1), .QUOTA(2), .AGE_LIMIT(64)
    ) dut_fp (
        .sdram_clk   (sdram_clk),
        .sdram_rst   (sdram_rst),
        .bus         (ifb),
        .grant_o     (gb),
        .grant_enc_o (geb)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] adr_tab [3];
    logic [15:0] dat_tab [3];
    logic [2:0]  we_tab;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step_a(input logic [2:0] acc,
                          input logic ack,
                          input logic idle);
        @(negedge sdram_clk);
        ifa.p_acc_i      = acc;
        ifa.ack_i        = ack;
        ifa.sdram_idle_i = idle;
        #1;
    endtask

    task automatic step_b(input logic [2:0] acc,
                          input logic ack,
                          input logic idle);
        @(negedge sdram_clk);
        ifb.p_acc_i      = acc;
        ifb.ack_i        = ack;
        ifb.sdram_idle_i = idle;
        #1;
    endtask

    // one full grant on the RR instance: IDLE, 4 acks, DRAIN
    task automatic grant_a(input int exp, input logic [2:0] acc);
        step_a(acc, 1'b0, 1'b1);
        check("a_idle_acc", ifa.acc_o, 0);
        for (int k = 0; k < 4; k++) begin
            step_a(acc, 1'b1, 1'b0);
            check("a_busy_acc", ifa.acc_o, 1);
            check("a_gnt", gea, exp);
            check("a_ack", ifa.p_ack_o, 3'b001 << exp);
            if (k == 0) begin
                check("a_adr", ifa.adr_o, adr_tab[exp]);
                check("a_dat", ifa.dat_o, dat_tab[exp]);
                check("a_we", ifa.we_o, we_tab[exp]);
            end
        end
        step_a(acc, 1'b0, 1'b1);
        check("a_drain_acc", ifa.acc_o, 0);
        check("a_drain_gnt", gea, exp);
    endtask

    // one full grant on the fixed-priority instance: 2 acks
    task automatic grant_b(input int exp, input logic [2:0] acc);
        step_b(acc, 1'b0, 1'b1);
        check("b_idle_acc", ifb.acc_o, 0);
        check("b_idle_ack", ifb.p_ack_o, 0);
        for (int k = 0; k < 2; k++) begin
            step_b(acc, 1'b1, 1'b0);
            check("b_busy_acc", ifb.acc_o, 1);
            check("b_gnt", gb, 3'b001 << exp);
            check("b_ack", ifb.p_ack_o, 3'b001 << exp);
        end
        step_b(acc, 1'b0, 1'b1);
        check("b_drain_acc", ifb.acc_o, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        adr_tab[0] = 32'hA000_0000;
        adr_tab[1] = 32'hB000_0001;
        adr_tab[2] = 32'hC000_0002;
        dat_tab[0] = 16'h1110;
        dat_tab[1] = 16'h2221;
        dat_tab[2] = 16'h3332;
        we_tab     = 3'b101;

        ifa.p_adr_i = {adr_tab[2], adr_tab[1], adr_tab[0]};
        ifa.p_dat_i = {dat_tab[2], dat_tab[1], dat_tab[0]};
        ifa.p_sel_i = 6'b11_10_01;
        ifa.p_we_i  = we_tab;
        ifa.dat_i   = 16'hBEEF;
        ifb.p_adr_i = ifa.p_adr_i;
        ifb.p_dat_i = ifa.p_dat_i;
        ifb.p_sel_i = ifa.p_sel_i;
        ifb.p_we_i  = we_tab;
        ifb.dat_i   = 16'h0000;
        ifb.p_acc_i      = 3'b000;
        ifb.ack_i        = 1'b0;
        ifb.sdram_idle_i = 1'b0;

        // reset state with everything asking
        ifa.p_acc_i      = 3'b111;
        ifa.ack_i        = 1'b1;
        ifa.sdram_idle_i = 1'b1;
        repeat (2) @(negedge sdram_clk);
        #1;
        check("rst_grant", ga, 3'b001);
        check("rst_enc", gea, 0);
        check("rst_acc", ifa.acc_o, 0);
        check("rst_ack", ifa.p_ack_o, 0);
        check("rst_adr", ifa.adr_o, 32'hA000_0000);
        check("rst_sel", ifa.sel_o, 2'b01);
        check("rd_bcast", ifa.p_dat_o, 16'hBEEF);

        @(negedge sdram_clk);
        ifa.p_acc_i      = 3'b000;
        ifa.ack_i        = 1'b0;
        ifa.sdram_idle_i = 1'b0;
        sdram_rst        = 1'b0;

        // round robin after last grant 0: 1,2,0,1
        grant_a(1, 3'b111);
        grant_a(2, 3'b111);
        grant_a(0, 3'b111);
        grant_a(1, 3'b111);

        // sole requester port 2: 10 acks, never drains
        step_a(3'b100, 1'b0, 1'b1);
        check("solo_idle_acc", ifa.acc_o, 0);
        for (int k = 0; k < 10; k++) begin
            step_a(3'b100, 1'b1, 1'b0);
            check("solo_acc", ifa.acc_o, 1);
            check("solo_ack", ifa.p_ack_o, 3'b100);
        end
        step_a(3'b100, 1'b0, 1'b0);
        check("solo_still_busy", ifa.acc_o, 1);

        // request drop, late ack in DRAIN, grant held until idle
        step_a(3'b000, 1'b0, 1'b0);
        check("drop_acc", ifa.acc_o, 0);
        step_a(3'b010, 1'b1, 1'b0);
        check("late_ack", ifa.p_ack_o, 3'b100);
        check("late_acc", ifa.acc_o, 0);
        check("late_gnt", ga, 3'b100);
        step_a(3'b010, 1'b0, 1'b0);
        check("hold_gnt", ga, 3'b100);
        step_a(3'b010, 1'b0, 1'b1);
        check("hold_gnt_idle", ga, 3'b100);
        step_a(3'b010, 1'b0, 1'b1);
        check("idle_acc", ifa.acc_o, 0);
        for (int k = 0; k < 3; k++) begin
            step_a(3'b010, 1'b1, 1'b0);
            check("p1_acc", ifa.acc_o, 1);
            check("p1_ack", ifa.p_ack_o, 3'b010);
        end

        // async reset mid-burst, port 1 with 3 acks done
        @(negedge sdram_clk);
        #2;
        sdram_rst = 1'b1;
        #1;
        check("mid_rst_acc", ifa.acc_o, 0);
        check("mid_rst_grant", ga, 3'b001);
        check("mid_rst_enc", gea, 0);
        check("mid_rst_ack", ifa.p_ack_o, 0);
        @(negedge sdram_clk);
        ifa.p_acc_i      = 3'b000;
        ifa.ack_i        = 1'b0;
        ifa.sdram_idle_i = 1'b0;
        sdram_rst        = 1'b0;

        // full quota of 4 again proves the counter cleared
        grant_a(1, 3'b011);

        // fixed priority, ports 0 and 2, quota 2
        grant_b(0, 3'b101);
        grant_b(2, 3'b101);
        grant_b(0, 3'b101);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
